// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with accumulator, registered result/flags and an optional
// iterative restoring divider enabled by the SEQ_ALU_DIV_EN macro.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             out_valid,
    output logic [2:0]       flags
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_ADDA = 4'h4;
    localparam logic [3:0] OP_MULA = 4'h5;
    localparam logic [3:0] OP_MAC  = 4'h6;
    localparam logic [3:0] OP_ROL  = 4'h7;
    localparam logic [3:0] OP_ROR  = 4'h8;
    localparam logic [3:0] OP_AND  = 4'h9;
    localparam logic [3:0] OP_OR   = 4'hA;
    localparam logic [3:0] OP_XOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_EQ   = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_LT   = 4'hF;

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   res;
    logic               res_carry;
    logic               res_dz;
    logic [WIDTH:0]     add_ab;
    logic [WIDTH:0]     sub_ab;
    logic [WIDTH:0]     add_acc;
    logic [WIDTH:0]     mac_sum;
    logic [2*WIDTH-1:0] mul_ab;
    logic [2*WIDTH-1:0] mul_acc;

    // Single-cycle datapath; MAC carry is taken from acc plus the truncated product.
    always_comb begin
        add_ab    = {1'b0, A} + {1'b0, B};
        sub_ab    = {1'b0, A} - {1'b0, B};
        add_acc   = {1'b0, acc} + {1'b0, A};
        mul_ab    = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        mul_acc   = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, A};
        mac_sum   = {1'b0, acc} + {1'b0, mul_ab[WIDTH-1:0]};
        res       = '0;
        res_carry = 1'b0;
        res_dz    = 1'b0;
        case (opcode)
            OP_ADD:  begin res = add_ab[WIDTH-1:0];  res_carry = add_ab[WIDTH];  end
            OP_SUB:  begin res = sub_ab[WIDTH-1:0];  res_carry = sub_ab[WIDTH];  end
            OP_MUL:  begin res = mul_ab[WIDTH-1:0];  res_carry = |mul_ab[2*WIDTH-1:WIDTH];  end
            OP_DIV:  begin res = '0;                 res_dz = 1'b1;              end
            OP_ADDA: begin res = add_acc[WIDTH-1:0]; res_carry = add_acc[WIDTH]; end
            OP_MULA: begin res = mul_acc[WIDTH-1:0]; res_carry = |mul_acc[2*WIDTH-1:WIDTH]; end
            OP_MAC:  begin res = mac_sum[WIDTH-1:0]; res_carry = mac_sum[WIDTH]; end
            OP_ROL:  res = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:  res = {A[0], A[WIDTH-1:1]};
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_NAND: res = ~(A & B);
            OP_EQ:   res = {WIDTH{A == B}};
            OP_GT:   res = {WIDTH{A > B}};
            OP_LT:   res = {WIDTH{A < B}};
            default: res = '0;
        endcase
    end

`ifdef SEQ_ALU_DIV_EN
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, DIV} state_t;

    state_t           state;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_den;
    logic [CW-1:0]    div_cnt;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] next_quo;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] div_result;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        div_shift  = {div_rem, div_quo[WIDTH-1]};
        div_ge     = (div_shift >= {1'b0, div_den});
        div_sub    = div_shift[WIDTH-1:0] - div_den;
        next_quo   = {div_quo[WIDTH-2:0], div_ge};
        next_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
        div_result = (div_den == '0) ? '1 : next_quo;
    end

    assign in_ready = (state == IDLE);
`else
    assign in_ready = 1'b1;
`endif

    // The accepting edge counts as the first; a divide finishes WIDTH edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ALU_Out   <= '0;
            flags     <= 3'b000;
            out_valid <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            state     <= IDLE;
            div_quo   <= '0;
            div_rem   <= '0;
            div_den   <= '0;
            div_cnt   <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (opcode == OP_DIV) begin
                            state   <= DIV;
                            div_quo <= A;
                            div_rem <= '0;
                            div_den <= B;
                            div_cnt <= '0;
                        end else begin
                            ALU_Out   <= res;
                            acc       <= res;
                            flags     <= {res_dz, res_carry, res == '0};
                            out_valid <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    div_quo <= next_quo;
                    div_rem <= next_rem;
                    div_cnt <= div_cnt + CW'(1);
                    if (div_cnt == CW'(WIDTH - 1)) begin
                        state     <= IDLE;
                        ALU_Out   <= div_result;
                        acc       <= div_result;
                        flags     <= {div_den == '0, 1'b0, div_result == '0};
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`else
            if (in_valid) begin
                ALU_Out   <= res;
                acc       <= res;
                flags     <= {res_dz, res_carry, res == '0};
                out_valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed, table-driven self-checking bench for seq_alu (WIDTH=8).
// Divider sequences are exercised when SEQ_ALU_DIV_EN is defined.
module tb_seq_alu;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] ALU_Out;
    logic       out_valid;
    logic [2:0] flags;

    int checks_total;
    int checks_passed;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_out;
        logic [2:0] exp_flags;
        string      name;
    } vec_t;

    vec_t vq[$];

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .A         (A),
        .B         (B),
        .ALU_Out   (ALU_Out),
        .out_valid (out_valid),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic addVec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_out, input logic [2:0] exp_flags, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_out = exp_out; v.exp_flags = exp_flags; v.name = name;
        vq.push_back(v);
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_out,
                               input logic [2:0] exp_flags, input logic exp_valid);
        checks_total++;
        if (ALU_Out === exp_out && flags === exp_flags && out_valid === exp_valid)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got out=0x%0h flags=%b valid=%b, expected out=0x%0h flags=%b valid=%b",
                     name, ALU_Out, flags, out_valid, exp_out, exp_flags, exp_valid);
    endtask

    // Drive one command for one edge, then drop in_valid just after that edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        opcode   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

`ifdef SEQ_ALU_DIV_EN
    // Keep a command on the bus while busy; it must be ignored. Returns edges until out_valid.
    task automatic waitDivResult(output int edges);
        edges = 0;
        opcode   = 4'h0;
        A        = 8'h01;
        B        = 8'h01;
        in_valid = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            if (in_ready !== 1'b0 && edges == 0)
                checkValue($sformatf("div_busy_ready_c%0d", n), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                edges = n;
                break;
            end
        end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        int edges;
        checks_total  = 0;
        checks_passed = 0;
        in_valid = 1'b0;
        opcode   = 4'h0;
        A        = 8'h00;
        B        = 8'h00;
        rst_n    = 1'b0;

        addVec(4'h0, 8'hF0, 8'h20, 8'h10, 3'b010, "add_carry");
        addVec(4'h0, 8'h03, 8'h04, 8'h07, 3'b000, "add_3_4");
        addVec(4'h6, 8'h02, 8'h05, 8'h11, 3'b000, "mac_2_5");
        addVec(4'h4, 8'h01, 8'h00, 8'h12, 3'b000, "adda_1");
        addVec(4'h7, 8'h81, 8'h00, 8'h03, 3'b000, "rol_81");
        addVec(4'hC, 8'hFF, 8'h0F, 8'hF0, 3'b000, "nand");
        addVec(4'h1, 8'h05, 8'h07, 8'hFE, 3'b010, "sub_borrow");
        addVec(4'h2, 8'h20, 8'h10, 8'h00, 3'b011, "mul_overflow");
        addVec(4'h4, 8'h03, 8'h00, 8'h03, 3'b000, "adda_3");
        addVec(4'h5, 8'h60, 8'h00, 8'h20, 3'b010, "mula_overflow");
        addVec(4'h6, 8'h10, 8'h10, 8'h20, 3'b000, "mac_trunc_prod");
        addVec(4'h8, 8'h01, 8'h00, 8'h80, 3'b000, "ror_01");
        addVec(4'h9, 8'hF0, 8'h3C, 8'h30, 3'b000, "and");
        addVec(4'hA, 8'h0F, 8'h30, 8'h3F, 3'b000, "or");
        addVec(4'hB, 8'hFF, 8'hFF, 8'h00, 3'b001, "xor_zero");
        addVec(4'hD, 8'h05, 8'h05, 8'hFF, 3'b000, "eq_true");
        addVec(4'hE, 8'h05, 8'h06, 8'h00, 3'b001, "gt_false");
        addVec(4'hF, 8'h05, 8'h06, 8'hFF, 3'b000, "lt_true");
        addVec(4'h4, 8'h01, 8'h00, 8'h00, 3'b011, "adda_wrap");
        addVec(4'h1, 8'h09, 8'h09, 8'h00, 3'b001, "sub_equal");
        addVec(4'h0, 8'hF0, 8'h00, 8'hF0, 3'b000, "add_f0");
        addVec(4'h6, 8'h04, 8'h05, 8'h04, 3'b010, "mac_carry");

        // Reset state, then release on a falling edge so the first command lands on the next edge
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", 8'h00, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkValue("ready_after_reset", {31'd0, in_ready}, 32'd1);

        foreach (vq[i]) begin
            applyStimulus(vq[i].op, vq[i].a, vq[i].b);
            checkOutput(vq[i].name, vq[i].exp_out, vq[i].exp_flags, 1'b1);
        end

        @(posedge clk);
        #1;
        checkOutput("hold_after_pulse", 8'h04, 3'b010, 1'b0);

`ifdef SEQ_ALU_DIV_EN
        applyStimulus(4'h3, 8'd200, 8'd7);
        waitDivResult(edges);
        checkValue("div_200_7_latency", edges, 32'd8);
        checkOutput("div_200_7", 8'd28, 3'b000, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("div_ignored_cmd", 8'd28, 3'b000, 1'b0);

        applyStimulus(4'h3, 8'd5, 8'd0);
        waitDivResult(edges);
        checkValue("div0_latency", edges, 32'd8);
        checkOutput("div_by_zero", 8'hFF, 3'b100, 1'b1);
        applyStimulus(4'h0, 8'h01, 8'h01);
        checkOutput("add_after_div0", 8'h02, 3'b000, 1'b1);

        applyStimulus(4'h3, 8'd200, 8'd7);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_div", 8'h00, 3'b000, 1'b0);
`else
        applyStimulus(4'h3, 8'd10, 8'd2);
        checkValue("nodiv_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("nodiv_div", 8'h00, 3'b101, 1'b1);
        applyStimulus(4'h4, 8'h04, 8'h00);
        checkOutput("nodiv_acc_cleared", 8'h04, 3'b000, 1'b1);

        applyStimulus(4'h0, 8'h11, 8'h22);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_run", 8'h00, 3'b000, 1'b0);
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", 8'h00, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'h4, 8'h09, 8'h00);
        checkOutput("adda_after_reset", 8'h09, 3'b000, 1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
